// File: rtl/traffic_pkg.sv
// Shared light encoding, phase enumeration and light-pair decode for the phase timer.
package traffic_pkg;

  localparam int unsigned LIGHT_W = 2;

  localparam logic [LIGHT_W-1:0] GREEN  = 2'b00;
  localparam logic [LIGHT_W-1:0] YELLOW = 2'b01;
  localparam logic [LIGHT_W-1:0] RED    = 2'b10;

  typedef enum logic [2:0] {
    HW_GREEN,
    HW_YELLOW,
    LN_GREEN,
    LN_YELLOW,
    ILLEGAL
  } phase_t;

  // Any pair outside the four legal combinations (including 2'b11) is ILLEGAL.
  function automatic phase_t decode(input logic [LIGHT_W-1:0] highway,
                                    input logic [LIGHT_W-1:0] lane);
    phase_t ph;
    ph = ILLEGAL;
    case ({highway, lane})
      {GREEN, RED}:  ph = HW_GREEN;
      {YELLOW, RED}: ph = HW_YELLOW;
      {RED, GREEN}:  ph = LN_GREEN;
      {RED, YELLOW}: ph = LN_YELLOW;
      default:       ph = ILLEGAL;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/traffic_phase_timer_sensor_debounce.sv
// Two-flop synchronizer plus symmetric debounce for the raw side-lane car detector.
module sensor_debounce #(
  parameter int unsigned DEBOUNCE = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] db_cnt;

  // dout flips only after DEBOUNCE consecutive synchronized samples disagree with it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      db_cnt <= '0;
      dout   <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
        db_cnt <= '0;
        dout   <= sync2;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_timer.sv
// Times each light phase, qualifies the car request and paces yellow for traffic_light_fsm.
module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int unsigned YELLOW_CYCLES  = 3,
  parameter int unsigned MIN_HW_GREEN   = 8,
  parameter int unsigned MAX_LANE_GREEN = 16,
  parameter int unsigned DEBOUNCE       = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             car_raw,
  input  logic [1:0]       highway,
  input  logic [1:0]       lane,
  output logic             sensor,
  output logic             delay_3sec,
  output logic             fault,
  output logic [CNT_W-1:0] phase_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HW_MIN     = CNT_W'(MIN_HW_GREEN - 1);
  localparam logic [CNT_W-1:0] LN_MAX     = CNT_W'(MAX_LANE_GREEN - 1);

  logic             car_present;
  phase_t           phase_q;
  phase_t           phase_d;
  logic             change;
  logic [CNT_W-1:0] cnt_d;
  logic             yellow_hit;
  logic             sensor_d;
  logic             delay_d;
  logic             fault_d;

  sensor_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (car_raw),
    .dout   (car_present)
  );

  // Phase/counter/output registers; outputs are computed from next-cycle state
  // so they line up with the phase_cnt value visible alongside them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_q    <= HW_GREEN;
      phase_cnt  <= '0;
      sensor     <= 1'b0;
      delay_3sec <= 1'b0;
      fault      <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      phase_cnt  <= cnt_d;
      sensor     <= sensor_d;
      delay_3sec <= delay_d;
      fault      <= fault_d;
    end
  end

  always_comb begin
    phase_d    = decode(highway, lane);
    change     = (phase_d != phase_q);
    cnt_d      = phase_cnt;
    sensor_d   = 1'b0;
    delay_d    = 1'b0;
    fault_d    = fault || (phase_d == ILLEGAL);

    if (change) begin
      cnt_d = '0;
    end else if (phase_cnt != CNT_MAX) begin
      cnt_d = phase_cnt + CNT_W'(1);
    end

    // Second term suppresses a repeat pulse if the counter saturates on the limit.
    yellow_hit = (cnt_d == YELLOW_END) && (change || (cnt_d != phase_cnt));

    case (phase_d)
      HW_GREEN:  sensor_d = car_present && (cnt_d >= HW_MIN);
      LN_GREEN:  sensor_d = car_present && (cnt_d < LN_MAX);
      HW_YELLOW: begin
        sensor_d = 1'b1;
        delay_d  = yellow_hit;
      end
      LN_YELLOW: delay_d = yellow_hit;
      default: begin
        sensor_d = 1'b0;
        delay_d  = 1'b0;
      end
    endcase

    if (fault_d) begin
      sensor_d = 1'b0;
      delay_d  = 1'b0;
    end
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed checks of traffic_phase_timer with default parameters, including a small closed-loop light model.
module tb_traffic_phase_timer;
  import traffic_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       car_raw;
  logic [1:0] highway;
  logic [1:0] lane;
  logic       sensor;
  logic       delay_3sec;
  logic       fault;
  logic [7:0] phase_cnt;

  int n_pass;
  int n_total;

  traffic_phase_timer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .car_raw   (car_raw),
    .highway   (highway),
    .lane      (lane),
    .sensor    (sensor),
    .delay_3sec(delay_3sec),
    .fault     (fault),
    .phase_cnt (phase_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n rising edges; return mid-cycle so outputs are stable and inputs can change.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic lights(input logic [1:0] h, input logic [1:0] l);
    highway = h;
    lane    = l;
  endtask

  initial begin
    int  st;
    int  lng_exit_cnt;
    logic done;
    logic saw_lny;

    n_pass  = 0;
    n_total = 0;
    reset_n = 1'b0;
    car_raw = 1'b1;
    lights(GREEN, RED);

    // Reset held 3 cycles with a car present
    step(3);
    chk("rst_sensor", 32'(sensor), 32'd0);
    chk("rst_delay", 32'(delay_3sec), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cnt", 32'(phase_cnt), 32'd0);
    reset_n = 1'b1;

    // Minimum highway green: sensor only once phase_cnt reaches 7
    for (int i = 1; i <= 7; i++) begin
      step(1);
      chk("mingreen_cnt", 32'(phase_cnt), 32'(i));
      chk("mingreen_sensor", 32'(sensor), 32'(i >= 7));
    end

    // Counter saturation
    step(248);
    chk("sat_cnt_reach", 32'(phase_cnt), 32'd255);
    step(3);
    chk("sat_cnt_hold", 32'(phase_cnt), 32'd255);
    chk("sat_sensor", 32'(sensor), 32'd1);

    // Highway yellow: single pulse 3 cycles after entry
    lights(YELLOW, RED);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("hwy_delay", 32'(delay_3sec), 32'(i == 3));
      chk("hwy_cnt", 32'(phase_cnt), 32'(i - 1));
    end
    chk("hwy_sensor", 32'(sensor), 32'd1);

    // Lane green with car held: forced low at phase_cnt 15
    lights(RED, GREEN);
    for (int i = 1; i <= 18; i++) begin
      step(1);
      chk("lng_sensor", 32'(sensor), 32'(i <= 15));
    end
    chk("lng_cnt", 32'(phase_cnt), 32'd17);

    // Lane yellow: single pulse, sensor held 0
    lights(RED, YELLOW);
    for (int i = 1; i <= 10; i++) begin
      step(1);
      chk("lny_delay", 32'(delay_3sec), 32'(i == 3));
      chk("lny_sensor", 32'(sensor), 32'd0);
    end

    // Phase change at the moment the count would hit the limit: no pulse
    lights(GREEN, RED);
    step(1);
    lights(RED, YELLOW);
    step(2);
    lights(YELLOW, RED);
    step(1);
    chk("simul_nopulse", 32'(delay_3sec), 32'd0);
    chk("simul_cnt", 32'(phase_cnt), 32'd0);
    step(2);
    chk("simul_newpulse", 32'(delay_3sec), 32'd1);
    step(1);
    chk("simul_once", 32'(delay_3sec), 32'd0);

    // Debounce release: sensor follows car_raw fall after 5 edges
    lights(GREEN, RED);
    step(10);
    chk("deb_pre", 32'(sensor), 32'd1);
    car_raw = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step(1);
      chk("deb_fall", 32'(sensor), 32'(i < 5));
    end

    // One-cycle glitch never qualifies
    car_raw = 1'b1;
    step(1);
    car_raw = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      step(1);
      chk("glitch", 32'(sensor), 32'd0);
    end

    // Three-cycle pulse qualifies after 2+2+1 edges, then releases
    car_raw = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      if (i == 3) car_raw = 1'b0;
      chk("hold3", 32'(sensor), 32'(i >= 5 && i <= 7));
    end

    // Illegal combination: sticky fault, outputs suppressed
    car_raw = 1'b1;
    step(6);
    chk("pre_fault_sensor", 32'(sensor), 32'd1);
    lights(GREEN, GREEN);
    step(1);
    chk("fault_set", 32'(fault), 32'd1);
    chk("fault_sensor", 32'(sensor), 32'd0);
    lights(GREEN, RED);
    step(12);
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_sensor_hold", 32'(sensor), 32'd0);
    lights(YELLOW, RED);
    for (int i = 1; i <= 5; i++) begin
      step(1);
      chk("fault_delay", 32'(delay_3sec), 32'd0);
    end
    lights(GREEN, RED);
    reset_n = 1'b0;
    step(1);
    chk("fault_clear", 32'(fault), 32'd0);
    chk("fault_clear_cnt", 32'(phase_cnt), 32'd0);
    reset_n = 1'b1;

    // Closed loop against a behavioural light sequencer, car always present
    st           = 0;
    done         = 1'b0;
    saw_lny      = 1'b0;
    lng_exit_cnt = -1;
    for (int i = 0; i < 300 && !done; i++) begin
      step(1);
      case (st)
        0: if (sensor) begin
          st = 1;
          lights(YELLOW, RED);
        end
        1: if (delay_3sec) begin
          st = 2;
          lights(RED, GREEN);
        end
        2: if (!sensor) begin
          lng_exit_cnt = int'(phase_cnt);
          st = 3;
          saw_lny = 1'b1;
          lights(RED, YELLOW);
        end
        default: if (delay_3sec) begin
          st   = 0;
          done = 1'b1;
          lights(GREEN, RED);
        end
      endcase
    end
    chk("loop_lny", 32'(saw_lny), 32'd1);
    chk("loop_done", 32'(done), 32'd1);
    chk("loop_lng_limit", 32'(lng_exit_cnt), 32'd15);
    step(1);
    chk("loop_hwg_cnt", 32'(phase_cnt), 32'd0);
    chk("loop_hwg_sensor", 32'(sensor), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
